// File: rtl/agc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : agc_sequencer
//  Description : Receive-path AGC control sequencer. Clears the AGC, waits a
//                settle period, runs the gain search with a timeout, freezes
//                gain while locked, re-acquires on sustained ADC overload
//                (bounded retries) and holds off after packet end.
//  Revision    : 1.0 - initial release
// ============================================================================
module agc_sequencer #(
    parameter int SETTLE_W  = 4,
    parameter int TIMEOUT_W = 11
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic                 energy_detect,
    input  logic                 overload,
    input  logic                 bs_done,
    input  logic                 packet_end,
    input  logic [SETTLE_W-1:0]  cfg_settle,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    output logic                 agc_clear,
    output logic                 agc_run,
    output logic                 gain_freeze,
    output logic                 timeout_flag,
    output logic                 retry_exhausted,
    output logic [2:0]           state_out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    // The holdoff counter parks at all-ones so a long RECOVER never wraps.
    localparam logic [SETTLE_W-1:0] c_settle_max = '1;
    localparam logic [1:0]          c_run_last   = 2'd3;
    localparam logic [1:0]          c_retry_max  = 2'd3;

    state_t               state_q,   state_d;
    logic [SETTLE_W-1:0]  settle_q,  settle_d;
    logic [TIMEOUT_W-1:0] tmo_q,     tmo_d;
    logic [1:0]           ovl_q,     ovl_d;
    logic [1:0]           retry_q,   retry_d;
    logic                 tflag_q,   tflag_d;
    logic                 rex_q,     rex_d;

    // Next-state and counter updates; enable low overrides everything but reset.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        ovl_d    = ovl_q;
        retry_d  = retry_q;
        tflag_d  = tflag_q;
        rex_d    = rex_q;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (energy_detect) begin
                        state_d = ST_CLEAR;
                        retry_d = 2'd0;
                        rex_d   = 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state_d  = ST_SETTLE;
                    tflag_d  = 1'b0;
                    settle_d = '0;
                end
                ST_SETTLE: begin
                    // >= keeps a lowered cfg_settle from causing a wrap-around.
                    if (settle_q >= cfg_settle) begin
                        state_d = ST_SEARCH;
                        tmo_d   = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_SEARCH: begin
                    // Search completion has priority over the timeout.
                    if (bs_done) begin
                        state_d = ST_LOCKED;
                        ovl_d   = 2'd0;
                    end else if (tmo_q >= cfg_timeout) begin
                        state_d = ST_LOCKED;
                        tflag_d = 1'b1;
                        ovl_d   = 2'd0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (packet_end) begin
                        state_d  = ST_RECOVER;
                        settle_d = '0;
                    end else if (overload) begin
                        if (ovl_q == c_run_last) begin
                            // Fourth consecutive overload cycle.
                            ovl_d = 2'd0;
                            if (retry_q != c_retry_max) begin
                                state_d = ST_CLEAR;
                                retry_d = retry_q + 1'b1;
                            end else begin
                                rex_d = 1'b1;
                            end
                        end else begin
                            ovl_d = ovl_q + 1'b1;
                        end
                    end else begin
                        ovl_d = 2'd0;
                    end
                end
                ST_RECOVER: begin
                    if ((settle_q >= cfg_settle) && !energy_detect) begin
                        state_d = ST_IDLE;
                    end else if (settle_q != c_settle_max) begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            ovl_q    <= 2'd0;
            retry_q  <= 2'd0;
            tflag_q  <= 1'b0;
            rex_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            ovl_q    <= ovl_d;
            retry_q  <= retry_d;
            tflag_q  <= tflag_d;
            rex_q    <= rex_d;
        end
    end

    // Control outputs decode the registered state only.
    assign agc_clear       = (state_q == ST_CLEAR);
    assign agc_run         = (state_q == ST_SEARCH);
    assign gain_freeze     = (state_q == ST_LOCKED);
    assign timeout_flag    = tflag_q;
    assign retry_exhausted = rex_q;
    assign state_out       = state_q;

endmodule
`default_nettype wire
